condiciona_botoes: RTL and testbench
====================================

Name: condiciona_botoes

Overview:
Input-conditioning stage directly upstream of the game datapath. It takes the 8 raw, asynchronous push-button lines, synchronises and debounces each one, and enforces a one-button-at-a-time rule. It delivers a registered one-hot jogada vector plus a single-cycle fez_jogada strobe, which the datapath consumes in place of the raw botoes bus and its own edge detection.

Parameters:
N_BOTOES, 8, number of button lines (width of botoes/jogada).
DEBOUNCE_CICLOS, 50000, consecutive stable synchronised samples required to accept a level change (1 ms at 50 MHz); minimum 2.
CW, $clog2(DEBOUNCE_CICLOS), debounce counter width (derived; not overridden).

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
botoes  input  N_BOTOES  raw button levels, active-high, asynchronous to clock.
habilita  input  1  from control unit; high = presses may generate fez_jogada.
jogada  output  N_BOTOES  one-hot code of last accepted press; held until next accepted press.
fez_jogada  output  1  one-cycle strobe, asserted on the cycle jogada updates.
jogada_invalida  output  1  one-cycle strobe on multi-button press detection.
db_botoes_estaveis  output  N_BOTOES  debounced levels, for debug.
db_estado  output  2  FSM state code, for debug.

Behaviour:
- Reset, synchronous and active-high, clears all state. Sync flops, counters, db_botoes_estaveis and jogada go to 0. fez_jogada and jogada_invalida go to 0. State goes to ESPERA (db_estado=0).
- Reset asserted mid-operation aborts any count or press. After release, held buttons are re-debounced from 0.
- Synchronisation: 2-flop chain per bit. The synchronised value is sampled from the second flop.
- Debounce, per bit independently:
  - If sync != estavel, the counter increments.
  - If sync == estavel, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CICLOS-1 while still differing, estavel <= sync and the counter clears.
  - Any glitch shorter than DEBOUNCE_CICLOS cycles never changes estavel.
- Latency:
  - Raw press held from cycle 0 gives estavel high at cycle DEBOUNCE_CICLOS+2.
  - fez_jogada pulses at cycle DEBOUNCE_CICLOS+3.
  - Release follows the same timing.
- FSM, evaluated on the estavel vector E:
  - ESPERA (0):
    - E==0: stay.
    - E one-hot and habilita=1: jogada<=E, fez_jogada=1 next cycle, go PRESSIONADO.
    - E one-hot and habilita=0: go PRESSIONADO without a strobe; jogada unchanged.
    - E with 2 or more bits set: jogada_invalida=1 for one cycle, go INVALIDO.
  - PRESSIONADO (1): extra buttons pressed are ignored (no strobe, no jogada change). Go to ESPERA only when E==0.
  - INVALIDO (2): wait for E==0, then go to ESPERA. No strobes.
  - Code 3 is unused. If ever reached, it goes to ESPERA on the next cycle.
- Simultaneous events:
  - Two bits becoming stable on the same cycle count as a multi-press (invalid).
  - Bits becoming stable on different cycles: the first one is accepted, later ones are ignored.
- fez_jogada and jogada_invalida are never high together. Each lasts exactly 1 cycle per press. Holding a button never repeats the strobe.
- habilita changing while in PRESSIONADO has no effect until the next ESPERA.

Optional Feature:
BOTOES_BYPASS_DEBOUNCE_EN.
- Defined: debounce counters are not instantiated and estavel equals the synchronised value. Latency is raw press to fez_jogada = 3 cycles. Intended for fast system-level simulation.
- Undefined (default, synthesis): full debounce as above. The port list is identical in both builds.

Decomposition:
- Shared package: FSM state encoding (ESPERA=2'd0, PRESSIONADO=2'd1, INVALIDO=2'd2) and default N_BOTOES=8, so db_estado decoding matches the top-level debug display.
- Natural sub-module: debounce_bit, a one-bit sync plus counter with parameter DEBOUNCE_CICLOS, instantiated N_BOTOES times via generate.
- The FSM and output registers stay in condiciona_botoes.

Test Plan (bench uses DEBOUNCE_CICLOS=4):
1. Clean press: habilita=1, botoes=8'h04 held 20 cycles then 0.
   - fez_jogada high exactly once, at cycle 7 after the edge.
   - jogada=8'h04 and held after release.
   - db_estado returns to 0 at cycle 7 after release.
2. Bounce rejection: botoes=8'h01 toggling every 2 cycles for 12 cycles, then steady 8'h01.
   - No strobe during toggling.
   - Single fez_jogada 7 cycles after the level settles.
3. Multi-press: botoes=8'h12 applied in one cycle.
   - jogada_invalida pulses once; fez_jogada stays 0; jogada unchanged.
   - State stays INVALIDO until botoes=0 is debounced.
4. Hold plus second button: 8'h01 accepted, then 8'h03 while holding.
   - No additional strobe; jogada stays 8'h01.
   - A subsequent full release then 8'h02 press gives fez_jogada with jogada=8'h02.
5. Disabled press: habilita=0 while pressing 8'h08, then habilita=1 while still held.
   - No strobe until release and a new press.
6. Reset mid-count: press 8'h20, assert reset at cycle 4 for 1 cycle, keep button held.
   - All outputs 0 during reset.
   - fez_jogada arrives 7 cycles after reset deasserts.

Source files
------------

// File: rtl/condiciona_botoes_pkg.sv
// Shared definitions for the button-conditioning stage: FSM state encoding
// (matches the debug display decoding of db_estado) and the default button count.
package condiciona_botoes_pkg;

  localparam int N_BOTOES_PADRAO = 8;

  typedef enum logic [1:0] {
    ESPERA      = 2'd0,
    PRESSIONADO = 2'd1,
    INVALIDO    = 2'd2
  } estado_t;

endpackage

// File: rtl/condiciona_botoes_if.sv
// Bus between the raw button/control side and the conditioning stage.
// master drives buttons and habilita; slave is the conditioning stage itself.
interface condiciona_botoes_if
  import condiciona_botoes_pkg::*;
#(
  parameter int N_BOTOES = N_BOTOES_PADRAO
);

  logic [N_BOTOES-1:0] botoes;
  logic                habilita;
  logic [N_BOTOES-1:0] jogada;
  logic                fez_jogada;
  logic                jogada_invalida;
  logic [N_BOTOES-1:0] db_botoes_estaveis;
  logic [1:0]          db_estado;

  modport master (
    output botoes,
    output habilita,
    input  jogada,
    input  fez_jogada,
    input  jogada_invalida,
    input  db_botoes_estaveis,
    input  db_estado
  );

  modport slave (
    input  botoes,
    input  habilita,
    output jogada,
    output fez_jogada,
    output jogada_invalida,
    output db_botoes_estaveis,
    output db_estado
  );

endinterface

// File: rtl/condiciona_botoes_debounce_bit.sv
// One button line: 2-flop synchroniser followed by a stability counter.
// Defining BOTOES_BYPASS_DEBOUNCE_EN removes the counter (estavel = synchronised level).
module condiciona_botoes_debounce_bit #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic estavel
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = botao;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef BOTOES_BYPASS_DEBOUNCE_EN

  assign estavel = sync2_q;

`else

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          estavel_q, estavel_d;

  // The level is accepted on the DEBOUNCE_CICLOS-th consecutive differing sample.
  always_comb begin
    cnt_d     = cnt_q;
    estavel_d = estavel_q;
    if (sync2_q == estavel_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMITE) begin
      estavel_d = sync2_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      estavel_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      estavel_q <= estavel_d;
    end
  end

  assign estavel = estavel_q;

`endif

endmodule

// File: rtl/condiciona_botoes.sv
// Button conditioning: per-bit sync/debounce plus a one-button-at-a-time FSM
// producing a registered one-hot jogada and single-cycle strobes.
module condiciona_botoes
  import condiciona_botoes_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input logic             clock,
  input logic             reset,
  condiciona_botoes_if.slave bus
);

  logic [N_BOTOES-1:0] estavel;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_debounce
    condiciona_botoes_debounce_bit #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .botao   (bus.botoes[i]),
      .estavel (estavel[i])
    );
  end

  estado_t             estado_q, estado_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                fez_jogada_q, fez_jogada_d;
  logic                jogada_invalida_q, jogada_invalida_d;

  // Only ESPERA reacts to new presses, so holding or adding buttons never re-strobes.
  always_comb begin
    estado_d          = estado_q;
    jogada_d          = jogada_q;
    fez_jogada_d      = 1'b0;
    jogada_invalida_d = 1'b0;
    case (estado_q)
      ESPERA: begin
        if ($countones(estavel) == 1) begin
          estado_d = PRESSIONADO;
          if (bus.habilita) begin
            jogada_d     = estavel;
            fez_jogada_d = 1'b1;
          end
        end else if ($countones(estavel) > 1) begin
          estado_d          = INVALIDO;
          jogada_invalida_d = 1'b1;
        end
      end
      PRESSIONADO, INVALIDO: begin
        if (estavel == '0) estado_d = ESPERA;
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q          <= ESPERA;
      jogada_q          <= '0;
      fez_jogada_q      <= 1'b0;
      jogada_invalida_q <= 1'b0;
    end else begin
      estado_q          <= estado_d;
      jogada_q          <= jogada_d;
      fez_jogada_q      <= fez_jogada_d;
      jogada_invalida_q <= jogada_invalida_d;
    end
  end

  assign bus.jogada             = jogada_q;
  assign bus.fez_jogada         = fez_jogada_q;
  assign bus.jogada_invalida    = jogada_invalida_q;
  assign bus.db_botoes_estaveis = estavel;
  assign bus.db_estado          = estado_q;

endmodule

// File: tb/tb_condiciona_botoes.sv
// Directed bench for condiciona_botoes (DEBOUNCE_CICLOS=4): stimulus queues expected
// strobes with their arrival cycle, a negedge monitor pops and checks them.
module tb_condiciona_botoes;
  import condiciona_botoes_pkg::*;

  localparam int LATENCIA = 7;

  typedef struct {
    bit         invalida;
    logic [7:0] jogada;
    int         ciclo;
  } esperado_t;

  logic clock;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  esperado_t fila[$];

  condiciona_botoes_if #(.N_BOTOES(8)) bus ();

  condiciona_botoes #(
    .N_BOTOES        (8),
    .DEBOUNCE_CICLOS (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    vectors++;
    if (atual !== esperado) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic h);
    @(negedge clock);
    bus.botoes   = b;
    bus.habilita = h;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expectStrobe(input bit invalida, input logic [7:0] jog);
    esperado_t e;
    e.invalida = invalida;
    e.jogada   = jog;
    e.ciclo    = cyc + LATENCIA;
    fila.push_back(e);
  endtask

  // Any strobe must match the oldest queued expectation in kind, jogada and cycle.
  always @(negedge clock) begin
    if (bus.fez_jogada || bus.jogada_invalida) begin
      checkOutput("strobes_exclusive", {31'd0, bus.fez_jogada & bus.jogada_invalida}, 32'd0);
      if (fila.size() == 0) begin
        checkOutput("unexpected_strobe", {30'd0, bus.jogada_invalida, bus.fez_jogada}, 32'd0);
      end else begin
        esperado_t e;
        e = fila.pop_front();
        checkOutput("strobe_kind", {31'd0, bus.jogada_invalida}, {31'd0, e.invalida});
        checkOutput("strobe_jogada", {24'd0, bus.jogada}, {24'd0, e.jogada});
        checkOutput("strobe_cycle", cyc, e.ciclo);
      end
    end
  end

  task automatic checkReset(input string nome);
    checkOutput({nome, "_jogada"}, {24'd0, bus.jogada}, 32'd0);
    checkOutput({nome, "_fez"}, {31'd0, bus.fez_jogada}, 32'd0);
    checkOutput({nome, "_invalida"}, {31'd0, bus.jogada_invalida}, 32'd0);
    checkOutput({nome, "_estaveis"}, {24'd0, bus.db_botoes_estaveis}, 32'd0);
    checkOutput({nome, "_estado"}, {30'd0, bus.db_estado}, {30'd0, ESPERA});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.botoes   = '0;
    bus.habilita = 1'b0;
    waitCycles(3);
    checkReset("reset");
    reset = 1'b0;
    waitCycles(2);

    // 1: clean press and release
    applyStimulus(8'h04, 1'b1);
    expectStrobe(1'b0, 8'h04);
    waitCycles(19);
    checkOutput("t1_estado_held", {30'd0, bus.db_estado}, {30'd0, PRESSIONADO});
    checkOutput("t1_estaveis", {24'd0, bus.db_botoes_estaveis}, 32'h04);
    applyStimulus(8'h00, 1'b1);
    waitCycles(6);
    checkOutput("t1_estado_before_release", {30'd0, bus.db_estado}, {30'd0, PRESSIONADO});
    waitCycles(1);
    checkOutput("t1_estado_released", {30'd0, bus.db_estado}, {30'd0, ESPERA});
    checkOutput("t1_jogada_held", {24'd0, bus.jogada}, 32'h04);
    waitCycles(3);

    // 2: bounce rejection, then steady press
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 8'h01 : 8'h00, 1'b1);
      waitCycles(1);
    end
    checkOutput("t2_estado_bounce", {30'd0, bus.db_estado}, {30'd0, ESPERA});
    applyStimulus(8'h01, 1'b1);
    expectStrobe(1'b0, 8'h01);
    waitCycles(12);
    applyStimulus(8'h00, 1'b1);
    waitCycles(10);

    // 3: multi-press
    applyStimulus(8'h12, 1'b1);
    expectStrobe(1'b1, 8'h01);
    waitCycles(12);
    checkOutput("t3_estado_invalido", {30'd0, bus.db_estado}, {30'd0, INVALIDO});
    checkOutput("t3_jogada_unchanged", {24'd0, bus.jogada}, 32'h01);
    applyStimulus(8'h00, 1'b1);
    waitCycles(6);
    checkOutput("t3_estado_still_invalido", {30'd0, bus.db_estado}, {30'd0, INVALIDO});
    waitCycles(1);
    checkOutput("t3_estado_espera", {30'd0, bus.db_estado}, {30'd0, ESPERA});
    waitCycles(3);

    // 4: hold plus second button, then release and new press
    applyStimulus(8'h01, 1'b1);
    expectStrobe(1'b0, 8'h01);
    waitCycles(12);
    applyStimulus(8'h03, 1'b1);
    waitCycles(12);
    checkOutput("t4_jogada_kept", {24'd0, bus.jogada}, 32'h01);
    checkOutput("t4_estado", {30'd0, bus.db_estado}, {30'd0, PRESSIONADO});
    checkOutput("t4_estaveis", {24'd0, bus.db_botoes_estaveis}, 32'h03);
    applyStimulus(8'h00, 1'b1);
    waitCycles(10);
    applyStimulus(8'h02, 1'b1);
    expectStrobe(1'b0, 8'h02);
    waitCycles(12);
    applyStimulus(8'h00, 1'b1);
    waitCycles(10);

    // 5: press while disabled, enable while held
    applyStimulus(8'h08, 1'b0);
    waitCycles(12);
    checkOutput("t5_estado_disabled", {30'd0, bus.db_estado}, {30'd0, PRESSIONADO});
    checkOutput("t5_jogada_unchanged", {24'd0, bus.jogada}, 32'h02);
    applyStimulus(8'h08, 1'b1);
    waitCycles(12);
    checkOutput("t5_jogada_still", {24'd0, bus.jogada}, 32'h02);
    applyStimulus(8'h00, 1'b1);
    waitCycles(10);
    applyStimulus(8'h08, 1'b1);
    expectStrobe(1'b0, 8'h08);
    waitCycles(12);
    applyStimulus(8'h00, 1'b1);
    waitCycles(10);

    // 6: reset mid-count with button held
    applyStimulus(8'h20, 1'b1);
    waitCycles(3);
    reset = 1'b1;
    waitCycles(1);
    checkReset("midreset");
    reset = 1'b0;
    expectStrobe(1'b0, 8'h20);
    waitCycles(12);
    applyStimulus(8'h00, 1'b1);
    waitCycles(10);

    checkOutput("pending_expected", fila.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
